// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze mesh: packet width, packet field positions,
// the packed packet layout and the link direction encoding.
// ---------------------------------------------------------------------------
package maze_pkg;

    localparam int PKT_W    = 23;

    // Packet field positions within a PKT_W-bit word
    localparam int TYPE_MSB = 22;
    localparam int TYPE_LSB = 21;
    localparam int QOS_BIT  = 20;
    localparam int SRC_MSB  = 19;
    localparam int SRC_LSB  = 14;
    localparam int TGT_MSB  = 13;
    localparam int TGT_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // First member lands on the MSBs, so this matches the field positions above
    typedef struct packed {
        logic [1:0] pkt_type;
        logic       qos;
        logic [5:0] src;
        logic [5:0] tgt;
        logic [7:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_W = 2'd1,
        DIR_S = 2'd2,
        DIR_E = 2'd3
    } dir_e;

endpackage

// File: rtl/maze_rr_arb.sv
// ---------------------------------------------------------------------------
// maze_rr_arb
// Purely combinational N-way round-robin arbiter. The caller owns the
// priority pointer; the search starts at i_ptr and wraps N-1 -> 0.
//
// Ports:
//   i_req      N      request vector
//   i_ptr      IDX_W  index searched first
//   o_gnt      N      one-hot grant (zero when no request)
//   o_gnt_idx  IDX_W  binary index of the grant (0 when no request)
//   o_gnt_vld  1      at least one request present
// ---------------------------------------------------------------------------
module maze_rr_arb #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    int v_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        v_idx     = 0;
        // Walk N positions starting at the pointer; the first hit wins
        for (int k = 0; k < N; k++) begin
            v_idx = int'(i_ptr) + k;
            if (v_idx >= N) begin
                v_idx = v_idx - N;
            end
            if (!o_gnt_vld && i_req[v_idx]) begin
                o_gnt[v_idx] = 1'b1;
                o_gnt_idx    = IDX_W'(v_idx);
                o_gnt_vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/maze_port_tx.sv
// ---------------------------------------------------------------------------
// maze_port_tx
// Transmit side of one mesh link. Picks one of N_IN packet sources per cycle
// (QoS class first, round-robin inside each class, with an anti-starvation
// override for the normal class), buffers the winner in a small FIFO and
// presents the FIFO head on a valid/ready link toward the neighbour.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   req_vld   in   N_IN        source i holds a packet
//   req_pkt   in   N_IN*PKT_W  packet of source i at [i*PKT_W +: PKT_W]
//   req_rdy   out  N_IN        one-hot grant; accept on req_vld&req_rdy
//   out_vld   out  1           link packet valid
//   out_pkt   out  PKT_W       link packet (FIFO head)
//   out_rdy   in   1           neighbour takes out_pkt this edge
//   fifo_cnt  out  CNT_W       FIFO occupancy
// ---------------------------------------------------------------------------
module maze_port_tx
    import maze_pkg::*;
#(
    parameter  int N_IN       = 4,
    parameter  int DEPTH      = 2,
    parameter  int STARVE_LIM = 4,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN-1:0]       req_vld,
    input  logic [N_IN*PKT_W-1:0] req_pkt,
    output logic [N_IN-1:0]       req_rdy,
    output logic                  out_vld,
    output logic [PKT_W-1:0]      out_pkt,
    input  logic                  out_rdy,
    output logic [CNT_W-1:0]      fifo_cnt
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_ptr_hi;
    logic [IDX_W-1:0] r_ptr_lo;
    logic [STV_W-1:0] r_starve;

    // ------------------------------------------------------------------
    // Split requests into the two QoS classes
    // ------------------------------------------------------------------
    pkt_t             w_src_pkt [N_IN];
    logic [N_IN-1:0]  w_hi_req;
    logic [N_IN-1:0]  w_lo_req;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_src
            assign w_src_pkt[gi] = pkt_t'(req_pkt[gi*PKT_W +: PKT_W]);
            assign w_hi_req[gi]  = req_vld[gi] &  w_src_pkt[gi].qos;
            assign w_lo_req[gi]  = req_vld[gi] & ~w_src_pkt[gi].qos;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-class round-robin arbiters
    // ------------------------------------------------------------------
    logic [N_IN-1:0]  w_hi_gnt;
    logic [N_IN-1:0]  w_lo_gnt;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;
    logic             w_any_hi;
    logic             w_any_lo;

    maze_rr_arb #(.N(N_IN)) u_arb_hi (
        .i_req     (w_hi_req),
        .i_ptr     (r_ptr_hi),
        .o_gnt     (w_hi_gnt),
        .o_gnt_idx (w_hi_idx),
        .o_gnt_vld (w_any_hi)
    );

    maze_rr_arb #(.N(N_IN)) u_arb_lo (
        .i_req     (w_lo_req),
        .i_ptr     (r_ptr_lo),
        .o_gnt     (w_lo_gnt),
        .o_gnt_idx (w_lo_idx),
        .o_gnt_vld (w_any_lo)
    );

    // ------------------------------------------------------------------
    // Class selection and grant
    // ------------------------------------------------------------------
    logic             w_starved;
    logic             w_sel_lo;
    logic [N_IN-1:0]  w_win_oh;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_next_ptr;
    logic             w_has_room;
    logic             w_push;
    logic             w_pop;

    assign w_starved = (r_starve == STV_W'(STARVE_LIM));
    // LO wins when it is being starved, or when no HI request competes
    assign w_sel_lo  = w_any_lo & (w_starved | ~w_any_hi);
    assign w_win_oh  = w_sel_lo ? w_lo_gnt : w_hi_gnt;
    assign w_win_idx = w_sel_lo ? w_lo_idx : w_hi_idx;

    // Room is judged on the registered count only, so out_rdy never reaches
    // req_rdy combinationally; a full FIFO refuses even if it pops this cycle.
    assign w_has_room = (r_cnt < CNT_W'(DEPTH));
    assign req_rdy    = (w_has_room && !rst) ? w_win_oh : '0;

    assign w_push = |(req_vld & req_rdy);
    assign w_pop  = out_vld & out_rdy;

    assign w_next_ptr = (w_win_idx == IDX_W'(N_IN - 1)) ? '0
                                                         : w_win_idx + IDX_W'(1);

    // ------------------------------------------------------------------
    // Starvation counter next value
    // ------------------------------------------------------------------
    logic [STV_W-1:0] w_starve_next;

    always_comb begin
        w_starve_next = r_starve;
        if (!w_any_lo) begin
            w_starve_next = '0;
        end else if (w_push && w_sel_lo) begin
            w_starve_next = '0;
        end else if (w_push && !w_starved) begin
            // HI grant while LO waits; saturates at STARVE_LIM
            w_starve_next = r_starve + STV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FIFO, pointers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ptr_hi <= '0;
            r_ptr_lo <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_src_pkt[w_win_idx];
                // DEPTH is a power of two, so the pointer wraps naturally
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                if (w_sel_lo) begin
                    r_ptr_lo <= w_next_ptr;
                end else begin
                    r_ptr_hi <= w_next_ptr;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_starve <= w_starve_next;
        end
    end

    // ------------------------------------------------------------------
    // Link outputs
    // ------------------------------------------------------------------
    assign out_vld  = (r_cnt != '0);
    assign out_pkt  = r_mem[r_rd_ptr];
    assign fifo_cnt = r_cnt;

endmodule

// File: tb/tb_maze_port_tx.sv
// ---------------------------------------------------------------------------
// tb_maze_port_tx
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the output port.
// ---------------------------------------------------------------------------
module tb_maze_port_tx;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;
    localparam int W     = 23;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_vld;
    logic [N*W-1:0]   req_pkt;
    logic [N-1:0]     req_rdy;
    logic             out_vld;
    logic [W-1:0]     out_pkt;
    logic             out_rdy;
    logic [1:0]       fifo_cnt;

    always #5 clk = ~clk;

    maze_port_tx #(
        .N_IN       (N),
        .DEPTH      (DEPTH),
        .STARVE_LIM (LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_pkt  (req_pkt),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_pkt  (out_pkt),
        .out_rdy  (out_rdy),
        .fifo_cnt (fifo_cnt)
    );

    // Packets currently offered by each source
    logic [W-1:0] src_pkt [N];

    // Reference model: FIFO contents, per-class pointers (0=LO, 1=HI), starve count
    logic [W-1:0] mq [$];
    int           m_ptr [2];
    int           m_starve;

    // Observed DUT outputs from the most recent step, before its clock edge
    logic         obs_vld;
    logic [W-1:0] obs_pkt;
    logic [1:0]   obs_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_pkt(input logic qos);
        logic [W-1:0] p;
        p     = W'($urandom);
        p[20] = qos;
        return p;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance
    // the model across the edge. Returns the accepted source or -1.
    task automatic step(input logic [N-1:0] vld, input logic rdy, input logic rs, output int g);
        logic         any_hi, any_lo, pushed, popped;
        logic [N-1:0] exp_rdy;
        int           cls, idx;
        req_vld = vld;
        for (int i = 0; i < N; i++) req_pkt[i*W +: W] = src_pkt[i];
        out_rdy = rdy;
        rst     = rs;
        #1;
        obs_vld = out_vld;
        obs_pkt = out_pkt;
        obs_cnt = fifo_cnt;

        any_hi = 1'b0;
        any_lo = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vld[i]) begin
                if (src_pkt[i][20]) any_hi = 1'b1;
                else                any_lo = 1'b1;
            end
        end
        g = -1;
        if (any_hi || any_lo) begin
            cls = (m_starve == LIM && any_lo) ? 0 : (any_hi ? 1 : 0);
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr[cls] + k) % N;
                if (g < 0 && vld[idx] && int'(src_pkt[idx][20]) == cls) g = idx;
            end
        end else begin
            cls = 0;
        end
        exp_rdy = '0;
        if (g >= 0 && mq.size() < DEPTH && !rs) exp_rdy[g] = 1'b1;

        check_val("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        check_val("out_vld", 32'(out_vld), 32'(mq.size() != 0));
        check_val("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        if (mq.size() != 0) check_val("out_pkt", 32'(out_pkt), 32'(mq[0]));

        pushed = (exp_rdy != '0);
        if (rs) begin
            mq.delete();
            m_ptr[0] = 0;
            m_ptr[1] = 0;
            m_starve = 0;
        end else begin
            popped = (mq.size() != 0) && rdy;
            if (popped) void'(mq.pop_front());
            if (pushed) begin
                mq.push_back(src_pkt[g]);
                m_ptr[cls] = (g + 1) % N;
            end
            if (!any_lo)                   m_starve = 0;
            else if (pushed && cls == 0)   m_starve = 0;
            else if (pushed && m_starve < LIM) m_starve = m_starve + 1;
        end
        if (!pushed) g = -1;
        $display("cyc t=%0t vld=%b rdy=%b rst=%b gnt=%0d cnt=%0d out_vld=%b out_pkt=%h",
                 $time, vld, rdy, rs, g, obs_cnt, obs_vld, obs_pkt);
        @(posedge clk);
        @(negedge clk);
    endtask

    int           g;
    logic [W-1:0] p1, p2, pa;
    int           exp_q [10] = '{1, 3, 1, 3, 2, 1, 3, 1, 3, 2};
    logic [N-1:0] hold;

    initial begin
        rst     = 1'b1;
        req_vld = '0;
        req_pkt = '0;
        out_rdy = 1'b0;
        for (int i = 0; i < N; i++) src_pkt[i] = '0;
        m_ptr[0] = 0;
        m_ptr[1] = 0;
        m_starve = 0;
        @(negedge clk);

        // Reset: request offered during reset must not be granted
        src_pkt[0] = rnd_pkt(1'b0);
        step(4'b0001, 1'b1, 1'b1, g);
        step(4'b0000, 1'b1, 1'b1, g);
        step(4'b0000, 1'b1, 1'b0, g);
        check_val("rst_cnt", 32'(obs_cnt), 32'd0);
        check_val("rst_vld", 32'(obs_vld), 32'd0);
        check_val("rst_pkt", 32'(obs_pkt), 32'd0);

        // Single packet: accept, visible next cycle, drained the cycle after
        src_pkt[0] = 23'h1A5A5A;
        step(4'b0001, 1'b1, 1'b0, g);
        check_val("single_acc", 32'(g), 32'd0);
        step(4'b0000, 1'b1, 1'b0, g);
        check_val("single_vld", 32'(obs_vld), 32'd1);
        check_val("single_pkt", 32'(obs_pkt), 32'h1A5A5A);
        step(4'b0000, 1'b1, 1'b0, g);
        check_val("single_cnt", 32'(obs_cnt), 32'd0);

        // Backpressure: sources 1 and 2 fill the FIFO, then drain in order
        step(4'b0000, 1'b1, 1'b1, g);
        p1 = rnd_pkt(1'b0);
        p2 = rnd_pkt(1'b0);
        src_pkt[1] = p1;
        src_pkt[2] = p2;
        step(4'b0110, 1'b0, 1'b0, g);
        check_val("bp_first", 32'(g), 32'd1);
        step(4'b0100, 1'b0, 1'b0, g);
        check_val("bp_second", 32'(g), 32'd2);
        src_pkt[3] = rnd_pkt(1'b0);
        step(4'b1000, 1'b0, 1'b0, g);
        check_val("bp_full_gnt", 32'(g), 32'hFFFF_FFFF);
        check_val("bp_full_cnt", 32'(obs_cnt), 32'd2);
        check_val("bp_hold_pkt", 32'(obs_pkt), 32'(p1));
        step(4'b0000, 1'b1, 1'b0, g);
        check_val("bp_drain1", 32'(obs_pkt), 32'(p1));
        step(4'b0000, 1'b1, 1'b0, g);
        check_val("bp_drain2", 32'(obs_pkt), 32'(p2));

        // Round-robin among four normal-class sources
        step(4'b0000, 1'b1, 1'b1, g);
        for (int i = 0; i < N; i++) src_pkt[i] = rnd_pkt(1'b0);
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b1, 1'b0, g);
            check_val("rr_gnt", 32'(g), 32'(k % 4));
            if (g >= 0) src_pkt[g] = rnd_pkt(1'b0);
        end

        // QoS priority with starvation relief
        step(4'b0000, 1'b1, 1'b1, g);
        src_pkt[1] = rnd_pkt(1'b1);
        src_pkt[2] = rnd_pkt(1'b0);
        src_pkt[3] = rnd_pkt(1'b1);
        for (int k = 0; k < 10; k++) begin
            step(4'b1110, 1'b1, 1'b0, g);
            check_val("qos_gnt", 32'(g), 32'(exp_q[k]));
            if (g >= 0) src_pkt[g] = rnd_pkt(src_pkt[g][20]);
        end

        // Mid-flight reset drops buffered packets
        step(4'b0000, 1'b1, 1'b1, g);
        src_pkt[0] = rnd_pkt(1'b0);
        src_pkt[1] = rnd_pkt(1'b0);
        step(4'b0011, 1'b0, 1'b0, g);
        step(4'b0010, 1'b0, 1'b0, g);
        step(4'b0100, 1'b0, 1'b1, g);
        src_pkt[3] = rnd_pkt(1'b0);
        step(4'b1000, 1'b1, 1'b0, g);
        check_val("mrst_cnt", 32'(obs_cnt), 32'd0);
        check_val("mrst_vld", 32'(obs_vld), 32'd0);
        check_val("mrst_gnt", 32'(g), 32'd3);

        // Push and pop in the same cycle
        step(4'b0000, 1'b1, 1'b1, g);
        pa = rnd_pkt(1'b0);
        src_pkt[0] = pa;
        step(4'b0001, 1'b0, 1'b0, g);
        src_pkt[0] = rnd_pkt(1'b0);
        p2 = src_pkt[0];
        step(4'b0001, 1'b1, 1'b0, g);
        check_val("pp_gnt", 32'(g), 32'd0);
        check_val("pp_head", 32'(obs_pkt), 32'(pa));
        step(4'b0000, 1'b0, 1'b0, g);
        check_val("pp_cnt", 32'(obs_cnt), 32'd1);
        check_val("pp_next", 32'(obs_pkt), 32'(p2));

        // Randomized traffic
        hold = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i]) begin
                    if ($urandom_range(31) == 0) hold[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    hold[i]    = 1'b1;
                    src_pkt[i] = rnd_pkt(1'($urandom_range(1)));
                end
            end
            step(hold, 1'($urandom_range(3) != 0), 1'($urandom_range(249) == 0), g);
            if (g >= 0) hold[g] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
